spi_tx_feeder: RTL and testbench

Upstream command stage for the SPI transmitter in the pulse-propagation-time meter. It buffers 16-bit setpoint words (DAC/threshold codes) from control logic in a small FIFO and launches them one at a time into the transmitter, using the transmitter's ready line as a handshake. It also enforces a minimum chip-select-high gap between frames and flags a transmitter that fails to start.

---
 rtl/spi_feed_pkg.sv | 28 ++
 rtl/spi_feed_fifo.sv | 53 +++++
 rtl/spi_tx_feeder.sv | 116 +++++++++++
 tb/tb_spi_tx_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_feed_pkg.sv
// Shared types and width helpers for the SPI transmit feeder.
// Holds the FSM state encoding and the FIFO entry and timer widths.
package spi_feed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        GAP
    } feed_state_e;

    // A FIFO entry is {edge_shape, data}.
    function automatic int entry_w(input int data_w);
        return data_w + 1;
    endfunction

    // The timer is shared by START and GAP, so it is sized for the larger limit.
    function automatic int timer_w(input int start_timeout, input int gap_cycles);
        int m;
        m = (start_timeout > gap_cycles) ? start_timeout : gap_cycles;
        return $clog2(m + 1);
    endfunction

    localparam int DATA_W_DEF  = 16;
    localparam int ENTRY_W     = entry_w(DATA_W_DEF);
    localparam int TIMER_W     = timer_w(15, 4);

endpackage

// File: rtl/spi_feed_fifo.sv
// Small synchronous FIFO with an asynchronous active-low reset.
// Overflow and underflow are blocked internally, so callers may be loose with push/pop.
module spi_feed_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap on their natural width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_feeder.sv
// Queues setpoint words and launches them one at a time into the SPI transmitter,
// enforcing an inter-frame gap and flagging a transmitter that never starts.
module spi_tx_feeder
    import spi_feed_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int GAP_CYCLES    = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_Wr_Valid,
    input  logic [DATA_W-1:0]             i_Wr_Data,
    input  logic                          i_Wr_EdgeShape,
    output logic                          o_Wr_Ready,
    input  logic                          i_Tx_Ready,
    output logic                          o_Tx_Enable,
    output logic [DATA_W-1:0]             o_Tx_Data,
    output logic                          o_Tx_EdgeShape,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level,
    output logic                          o_Busy,
    input  logic                          i_Err_Clear,
    output logic                          o_Err_Timeout
);

    localparam int EW = entry_w(DATA_W);
    localparam int TW = timer_w(START_TIMEOUT, GAP_CYCLES);

    feed_state_e   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [EW-1:0] head;
    logic          full, empty;
    logic          push, launch;
    logic          en_nxt, err_set;

    assign o_Wr_Ready = !full;
    assign push       = i_Wr_Valid && !full;
    assign o_Busy     = !empty || (state != IDLE);

    spi_feed_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .push  (push),
        .pop   (launch),
        .wdata ({i_Wr_EdgeShape, i_Wr_Data}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (o_Level)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        en_nxt    = 1'b0;
        launch    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && i_Tx_Ready) begin
                    launch    = 1'b1;
                    en_nxt    = 1'b1;
                    timer_nxt = '0;
                    state_nxt = START;
                end
            end
            START: begin
                // Enable is held for at most START_TIMEOUT clocks; the word is dropped on timeout.
                if (!i_Tx_Ready) begin
                    state_nxt = SHIFT;
                end else if (timer == TW'(START_TIMEOUT - 1)) begin
                    err_set   = 1'b1;
                    timer_nxt = '0;
                    state_nxt = GAP;
                end else begin
                    en_nxt    = 1'b1;
                    timer_nxt = timer + 1'b1;
                end
            end
            SHIFT: begin
                if (i_Tx_Ready) begin
                    timer_nxt = '0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (timer == TW'(GAP_CYCLES - 1)) state_nxt = IDLE;
                else                              timer_nxt = timer + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state          <= IDLE;
            timer          <= '0;
            o_Tx_Enable    <= 1'b0;
            o_Tx_Data      <= '0;
            o_Tx_EdgeShape <= 1'b0;
            o_Err_Timeout  <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            o_Tx_Enable <= en_nxt;
            if (launch) {o_Tx_EdgeShape, o_Tx_Data} <= head;
            if (err_set)          o_Err_Timeout <= 1'b1;
            else if (i_Err_Clear) o_Err_Timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Scoreboard bench for spi_tx_feeder: stimulus queues expected frames, a monitor
// pops and checks each launch; a behavioural transmitter model drives ready.
module tb_spi_tx_feeder;

    typedef struct {
        logic [15:0] data;
        logic        shape;
        int          len;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_shape;
    logic        wr_ready;
    logic        tx_ready;
    logic        en;
    logic [15:0] tx_data;
    logic        tx_shape;
    logic [2:0]  level;
    logic        busy;
    logic        err_clr;
    logic        err;

    logic        model_rdy;
    logic        hold_low;
    logic        never_start;

    frame_t      exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          launches = 0;

    always #5 clk = ~clk;

    assign tx_ready = model_rdy && !hold_low;

    spi_tx_feeder #(
        .DATA_W(16), .FIFO_DEPTH(4), .GAP_CYCLES(4), .START_TIMEOUT(15)
    ) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Wr_Valid     (wr_valid),
        .i_Wr_Data      (wr_data),
        .i_Wr_EdgeShape (wr_shape),
        .o_Wr_Ready     (wr_ready),
        .i_Tx_Ready     (tx_ready),
        .o_Tx_Enable    (en),
        .o_Tx_Data      (tx_data),
        .o_Tx_EdgeShape (tx_shape),
        .o_Level        (level),
        .o_Busy         (busy),
        .i_Err_Clear    (err_clr),
        .o_Err_Timeout  (err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void expect_frame(input logic [15:0] d, input logic s, input int l);
        frame_t f;
        f.data  = d;
        f.shape = s;
        f.len   = l;
        exp_q.push_back(f);
    endfunction

    task automatic wr(input logic [15:0] d, input logic s);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_shape = s;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    // Transmitter model: drops ready 3 clocks after enable, holds it low 40 clocks.
    initial begin
        model_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (en && !never_start) begin
                repeat (2) @(negedge clk);
                model_rdy = 1'b0;
                repeat (40) @(negedge clk);
                model_rdy = 1'b1;
            end
        end
    end

    // Monitor: one expected frame per enable pulse, checked at rise and fall.
    initial begin
        frame_t cur;
        bit     in_frame = 1'b0;
        int     len = 0;
        cur.data = '0; cur.shape = 1'b0; cur.len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
            end else if (en && !in_frame) begin
                in_frame = 1'b1;
                len = 1;
                launches++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_launch", {16'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    cur = exp_q.pop_front();
                    chk("launch_data", {16'd0, tx_data}, {16'd0, cur.data});
                    chk("launch_shape", {31'd0, tx_shape}, {31'd0, cur.shape});
                end
            end else if (en && in_frame) begin
                len++;
            end else if (!en && in_frame) begin
                in_frame = 1'b0;
                chk("enable_len", len, cur.len);
                chk("data_stable", {16'd0, tx_data}, {16'd0, cur.data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int snap;
        logic [15:0] words [6];
        words[0] = 16'h0101; words[1] = 16'h0202; words[2] = 16'h0303;
        words[3] = 16'h0404; words[4] = 16'h0505; words[5] = 16'h0606;

        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_shape = 1'b0;
        err_clr = 1'b0; hold_low = 1'b0; never_start = 1'b0;
        #3;
        chk("rst_en", {31'd0, en}, 0);
        chk("rst_data", {16'd0, tx_data}, 0);
        chk("rst_shape", {31'd0, tx_shape}, 0);
        chk("rst_level", {29'd0, level}, 0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {31'd0, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word: latency, enable width, busy tail after ready returns.
        expect_frame(16'd800, 1'b0, 3);
        wr(16'd800, 1'b0);
        chk("lat_level1", {29'd0, level}, 1);
        chk("lat_en0", {31'd0, en}, 0);
        @(negedge clk);
        chk("lat_en1", {31'd0, en}, 1);
        chk("lat_level0", {29'd0, level}, 0);
        n = 0;
        do begin @(posedge clk); n++; end while (tx_ready && n < 100);
        n = 0;
        do begin @(posedge clk); n++; end while (!tx_ready && n < 100);
        chk("ready_rise_seen", {31'd0, tx_ready}, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 100);
        chk("busy_tail", n, 5);
        chk("no_err", {31'd0, err}, 0);

        // Burst into a full FIFO with the transmitter busy.
        hold_low = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                chk("full_level", {29'd0, level}, 4);
                chk("full_wr_ready", {31'd0, wr_ready}, 0);
            end
            if (i < 4) expect_frame(words[i], i[0], 3);
            wr_valid = 1'b1; wr_data = words[i]; wr_shape = i[0];
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("burst_level", {29'd0, level}, 4);
        // Pop and write together while full: the write is refused.
        hold_low = 1'b0;
        wr(16'h0707, 1'b1);
        chk("full_pushpop_level", {29'd0, level}, 3);
        wait_idle(2000);
        chk("burst_drained", exp_q.size(), 0);

        // Push and pop together at level 2: level unchanged.
        hold_low = 1'b1;
        expect_frame(16'h1111, 1'b1, 3);
        expect_frame(16'h2222, 1'b0, 3);
        expect_frame(16'h3333, 1'b1, 3);
        wr(16'h1111, 1'b1);
        wr(16'h2222, 1'b0);
        chk("lvl2_before", {29'd0, level}, 2);
        hold_low = 1'b0;
        wr(16'h3333, 1'b1);
        chk("lvl2_pushpop", {29'd0, level}, 2);
        wait_idle(2000);

        // Start timeout, clear, then a timeout coinciding with a clear.
        never_start = 1'b1;
        expect_frame(16'hABCD, 1'b1, 15);
        expect_frame(16'h1234, 1'b0, 15);
        wr(16'hABCD, 1'b1);
        wr(16'h1234, 1'b0);
        n = 0;
        while (!en && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (en && n < 50) begin @(negedge clk); n++; end
        chk("to_err_set", {31'd0, err}, 1);
        err_clr = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                err_clr = 1'b0;
                chk("to_err_cleared", {31'd0, err}, 0);
            end
        end while (!en && n < 50);
        chk("to_gap_relaunch", n, 5);
        repeat (14) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_set_beats_clear", {31'd0, err}, 1);
        chk("to_en_dropped", {31'd0, en}, 0);
        never_start = 1'b0;
        wait_idle(200);

        // Reset during SHIFT with three words queued.
        expect_frame(16'h0A0A, 1'b0, 3);
        wr(16'h0A0A, 1'b0);
        wr(16'h0B0B, 1'b1);
        wr(16'h0C0C, 1'b0);
        wr(16'h0D0D, 1'b1);
        n = 0;
        while (!en && n < 50) begin @(negedge clk); n++; end
        while (en && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("pre_rst_level", {29'd0, level}, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {31'd0, en}, 0);
        chk("mid_rst_data", {16'd0, tx_data}, 0);
        chk("mid_rst_level", {29'd0, level}, 0);
        chk("mid_rst_wr_ready", {31'd0, wr_ready}, 1);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_err", {31'd0, err}, 0);
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        snap = launches;
        repeat (80) @(negedge clk);
        chk("no_launch_after_rst", launches - snap, 0);
        expect_frame(16'h0E0E, 1'b1, 3);
        wr(16'h0E0E, 1'b1);
        wait_idle(200);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
